// File: rtl/pipe_pkg.sv
// Shared types and default widths for the inter-stage pipeline register.
package pipe_pkg;

    localparam int PIPE_CTRL_W = 8;
    localparam int PIPE_DATA_W = 128;
    localparam int PIPE_CNT_W  = 16;

    // Control value presented whenever the stage holds a bubble.
    localparam logic [PIPE_CTRL_W-1:0] CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        PS_EMPTY,
        PS_FULL,
        PS_SKID
    } pipe_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// One-entry holding slot used to absorb the entry that arrives while the
// output is stalled, so in_ready can be a registered signal.
module pipe_skid_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         unload,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Slot contents: clear wins, load captures, unload zeroes the emptied slot.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (unload) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, stall, flush and
// bubble insertion. Control bits read as zero whenever the stage is empty.
// Build option SKID_BUFFER_EN: adds a one-entry skid slot and makes in_ready
// a registered signal (no combinational out_ready -> in_ready path).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              bubble,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_e       state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic              in_fire;
    logic              load_in;
    logic              clr_main;

`ifdef SKID_BUFFER_EN
    logic                     rdy_q;
    logic                     skid_load;
    logic                     skid_unload;
    logic [CTRL_W+DATA_W-1:0] skid_q;

    pipe_skid_slot #(
        .W(CTRL_W + DATA_W)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .unload(skid_unload),
        .clear (flush),
        .d     ({in_ctrl, in_data}),
        .q     (skid_q)
    );

    // Registered ready: low exactly while the skid slot is occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q <= 1'b1;
        end else begin
            rdy_q <= (state_d != PS_SKID);
        end
    end

    assign in_ready = rdy_q & ~bubble;
`else
    assign in_ready = (~out_valid | out_ready) & ~bubble;
`endif

    assign out_valid = (state_q != PS_EMPTY);
    assign in_fire   = in_valid & in_ready & ~flush;
    assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_W'(CTRL_BUBBLE);
    assign out_data  = main_data_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PS_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and slot steering; flush drops everything, including this cycle's input.
    always_comb begin
        state_d  = state_q;
        load_in  = 1'b0;
        clr_main = 1'b0;
`ifdef SKID_BUFFER_EN
        skid_load   = 1'b0;
        skid_unload = 1'b0;
`endif
        if (flush) begin
            state_d  = PS_EMPTY;
            clr_main = 1'b1;
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    if (in_fire) begin
                        state_d = PS_FULL;
                        load_in = 1'b1;
                    end
                end
                PS_FULL: begin
                    if (in_fire && out_ready) begin
                        load_in = 1'b1;
`ifdef SKID_BUFFER_EN
                    end else if (in_fire) begin
                        state_d   = PS_SKID;
                        skid_load = 1'b1;
`endif
                    end else if (out_ready) begin
                        state_d  = PS_EMPTY;
                        clr_main = 1'b1;
                    end
                end
`ifdef SKID_BUFFER_EN
                PS_SKID: begin
                    if (out_ready) begin
                        state_d     = PS_FULL;
                        skid_unload = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d  = PS_EMPTY;
                    clr_main = 1'b1;
                end
            endcase
        end
    end

    // Main slot: zeroed when emptied so idle outputs match the reset value.
    always_ff @(posedge clk) begin
        if (rst || clr_main) begin
            main_ctrl_q <= '0;
            main_data_q <= '0;
        end else if (load_in) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
`ifdef SKID_BUFFER_EN
        end else if (skid_unload) begin
            {main_ctrl_q, main_data_q} <= skid_q;
`endif
        end
    end

    // Saturating count of stalled output cycles; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
